// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-side arbiter.
package fifo_wr_arbiter_pkg;

   localparam int unsigned NUM_REQ_DEF    = 2;
   localparam int unsigned DATA_WIDTH_DEF = 8;
   localparam int unsigned PTR_WIDTH_DEF  = 2;
   localparam int unsigned PKT_WIDTH_DEF  = 2 * DATA_WIDTH_DEF;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      SEND_LO = 2'b01,
      SEND_HI = 2'b10
   } state_e;

   // A packet carries up to two FIFO words.
   function automatic int unsigned pkt_width(input int unsigned dw);
      return 2 * dw;
   endfunction

   // Round-robin successor of a served requester.
   function automatic int unsigned rr_next(input int unsigned owner, input int unsigned n);
      return (owner + 1) % n;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin select: first set request at or above ptr, else wrap to lowest.
module rr_arbiter #(
   parameter int unsigned NUM_REQ   = 2,
   parameter int unsigned PTR_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]   req,
   input  logic [PTR_WIDTH-1:0] ptr,
   output logic [NUM_REQ-1:0]   gnt_c,
   output logic                 valid_c
);

   int unsigned start_c;
   logic        found_hi_c;
   logic        found_lo_c;

   // Two passes: upper region from ptr, then wrap-around from index 0.
   always_comb begin
      gnt_c      = '0;
      found_hi_c = 1'b0;
      found_lo_c = 1'b0;
      start_c    = 32'(ptr) % NUM_REQ;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (req[i] && (i >= start_c) && !found_hi_c) begin
            gnt_c[i]   = 1'b1;
            found_hi_c = 1'b1;
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (req[i] && !found_hi_c && !found_lo_c) begin
            gnt_c[i]   = 1'b1;
            found_lo_c = 1'b1;
         end
      end
      valid_c = found_hi_c | found_lo_c;
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side scheduler: round-robin grant of 1/2-byte packets streamed into the FIFO.
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned PTR_WIDTH  = PTR_WIDTH_DEF
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic [NUM_REQ-1:0]              REQ,
   input  logic [NUM_REQ*2*DATA_WIDTH-1:0] REQ_DATA,
   input  logic [NUM_REQ-1:0]              REQ_TWO,
   output logic [NUM_REQ-1:0]              GNT,
   output logic [NUM_REQ-1:0]              DONE,
   input  logic                            FULL,
   output logic                            W_INC,
   output logic [DATA_WIDTH-1:0]           WR_DATA,
   output logic                            BUSY
);

   localparam int unsigned PKT_WIDTH = pkt_width(DATA_WIDTH);

   state_e                 state_q,   state_d;
   logic [PTR_WIDTH-1:0]   rr_ptr_q,  rr_ptr_d;
   logic [PKT_WIDTH-1:0]   pkt_q,     pkt_d;
   logic                   two_q,     two_d;
   logic [PTR_WIDTH-1:0]   owner_q,   owner_d;
   logic                   w_inc_q,   w_inc_d;
   logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
   logic                   busy_q,    busy_d;

   logic [NUM_REQ-1:0]     arb_gnt_c;
   logic                   arb_valid_c;
   logic                   accept_c;
   logic                   last_c;

   rr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .PTR_WIDTH (PTR_WIDTH)
   ) u_rr_arbiter (
      .req     (REQ),
      .ptr     (rr_ptr_q),
      .gnt_c   (arb_gnt_c),
      .valid_c (arb_valid_c)
   );

   // Same acceptance qualification the FIFO applies; last_c marks the final byte of a packet.
   assign accept_c = w_inc_q & ~FULL;
   assign last_c   = accept_c & ((state_q == SEND_HI) | ((state_q == SEND_LO) & ~two_q));

   // State, latched packet and registered FIFO-side outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         pkt_q     <= '0;
         two_q     <= 1'b0;
         owner_q   <= '0;
         w_inc_q   <= 1'b0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         pkt_q     <= pkt_d;
         two_q     <= two_d;
         owner_q   <= owner_d;
         w_inc_q   <= w_inc_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
      end
   end

   // Next state, packet latch, pointer update and next FIFO-side outputs.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      pkt_d    = pkt_q;
      two_d    = two_q;
      owner_d  = owner_q;
      case (state_q)
         IDLE: begin
            if (arb_valid_c) begin
               state_d = SEND_LO;
               for (int unsigned i = 0; i < NUM_REQ; i++) begin
                  if (arb_gnt_c[i]) begin
                     pkt_d   = REQ_DATA[i*PKT_WIDTH +: PKT_WIDTH];
                     two_d   = REQ_TWO[i];
                     owner_d = PTR_WIDTH'(i);
                  end
               end
            end
         end
         SEND_LO: begin
            if (accept_c) begin
               if (two_q) begin
                  state_d = SEND_HI;
               end else begin
                  state_d  = IDLE;
                  rr_ptr_d = PTR_WIDTH'(rr_next(32'(owner_q), NUM_REQ));
               end
            end
         end
         SEND_HI: begin
            if (accept_c) begin
               state_d  = IDLE;
               rr_ptr_d = PTR_WIDTH'(rr_next(32'(owner_q), NUM_REQ));
            end
         end
         default: state_d = IDLE;
      endcase

      w_inc_d = (state_d != IDLE);
      busy_d  = (state_d != IDLE);
      case (state_d)
         SEND_LO: wr_data_d = pkt_d[DATA_WIDTH-1:0];
         SEND_HI: wr_data_d = pkt_d[PKT_WIDTH-1:DATA_WIDTH];
         default: wr_data_d = '0;
      endcase
   end

   // Output decode: grant while idle, completion on the last accepted byte.
   always_comb begin
      GNT     = (state_q == IDLE) ? arb_gnt_c : '0;
      DONE    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (last_c && (owner_q == PTR_WIDTH'(i))) begin
            DONE[i] = 1'b1;
         end
      end
      W_INC   = w_inc_q;
      WR_DATA = wr_data_q;
      BUSY    = busy_q;
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stimulus pushes expectations, monitor pops and compares.
module tb_fifo_wr_arbiter;

   logic        CLK;
   logic        RST;
   logic [1:0]  REQ;
   logic [31:0] REQ_DATA;
   logic [1:0]  REQ_TWO;
   logic [1:0]  GNT;
   logic [1:0]  DONE;
   logic        FULL;
   logic        W_INC;
   logic [7:0]  WR_DATA;
   logic        BUSY;

   typedef struct {
      logic [15:0] d;
      logic        two;
   } pkt_t;

   int n_checks = 0;
   int n_errors = 0;

   logic [1:0] exp_gnt[$];
   logic [1:0] exp_done[$];
   logic [7:0] exp_byte[$];
   pkt_t       q0[$];
   pkt_t       q1[$];

   int gnt_cnt[2]  = '{0, 0};
   int done_cnt[2] = '{0, 0};
   int iss_gnt[2]  = '{0, 0};
   int iss_done[2] = '{0, 0};

   fifo_wr_arbiter #(
      .NUM_REQ    (2),
      .DATA_WIDTH (8),
      .PTR_WIDTH  (2)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .REQ      (REQ),
      .REQ_DATA (REQ_DATA),
      .REQ_TWO  (REQ_TWO),
      .GNT      (GNT),
      .DONE     (DONE),
      .FULL     (FULL),
      .W_INC    (W_INC),
      .WR_DATA  (WR_DATA),
      .BUSY     (BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_pkt(input int r, input logic [15:0] d, input logic two);
      logic [1:0] oh;
      oh = 2'(1) << r;
      exp_gnt.push_back(oh);
      exp_byte.push_back(d[7:0]);
      if (two) exp_byte.push_back(d[15:8]);
      exp_done.push_back(oh);
      iss_gnt[r]++;
      iss_done[r]++;
   endtask

   // Expected order for two always-requesting streams of equal length, requester 0 first.
   task automatic push_pairs();
      for (int k = 0; k < q0.size(); k++) begin
         push_pkt(0, q0[k].d, q0[k].two);
         push_pkt(1, q1[k].d, q1[k].two);
      end
   endtask

   // Requesters hold REQ until granted, drop it for one cycle, then present the next packet.
   task automatic run_streams(input bit rand_full);
      bit drop0 = 1'b0;
      bit drop1 = 1'b0;
      int cyc   = 0;
      while (q0.size() != 0 || q1.size() != 0 || exp_done.size() != 0) begin
         @(posedge CLK);
         #1;
         REQ[0] = (q0.size() != 0) && !drop0;
         REQ[1] = (q1.size() != 0) && !drop1;
         REQ_DATA[15:0]  = (q0.size() != 0) ? q0[0].d : 16'h0;
         REQ_DATA[31:16] = (q1.size() != 0) ? q1[0].d : 16'h0;
         REQ_TWO[0] = (q0.size() != 0) ? q0[0].two : 1'b0;
         REQ_TWO[1] = (q1.size() != 0) ? q1[0].two : 1'b0;
         FULL = rand_full ? ($urandom_range(0, 2) == 0) : 1'b0;
         @(negedge CLK);
         drop0 = GNT[0];
         drop1 = GNT[1];
         if (GNT[0] && q0.size() != 0) void'(q0.pop_front());
         if (GNT[1] && q1.size() != 0) void'(q1.pop_front());
         cyc++;
         if (cyc > 5000) begin
            n_checks++;
            n_errors++;
            $display("FAIL stream_timeout: pending done=%0d expected 0", exp_done.size());
            break;
         end
      end
      step();
      REQ  = 2'b00;
      FULL = 1'b0;
   endtask

   // Monitor: every grant, accepted byte and completion is checked against the scoreboard.
   always @(negedge CLK) begin
      if (GNT != 2'b00) begin
         if (exp_gnt.size() == 0) chk("unexpected_gnt", 32'(GNT), 32'h0);
         else chk("gnt_order", 32'(GNT), 32'(exp_gnt.pop_front()));
         for (int i = 0; i < 2; i++) if (GNT[i]) gnt_cnt[i]++;
      end
      if (W_INC && !FULL) begin
         if (exp_byte.size() == 0) chk("unexpected_byte", 32'(WR_DATA), 32'h0);
         else chk("fifo_byte", 32'(WR_DATA), 32'(exp_byte.pop_front()));
      end
      if (DONE != 2'b00) begin
         if (exp_done.size() == 0) chk("unexpected_done", 32'(DONE), 32'h0);
         else chk("done_order", 32'(DONE), 32'(exp_done.pop_front()));
         for (int i = 0; i < 2; i++) if (DONE[i]) done_cnt[i]++;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: sim time expired, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      RST      = 1'b1;
      REQ      = 2'b00;
      REQ_DATA = 32'h0;
      REQ_TWO  = 2'b00;
      FULL     = 1'b0;
      #1 RST = 1'b0;

      // Reset state
      repeat (2) @(negedge CLK);
      chk("rst_gnt",   32'(GNT),     32'h0);
      chk("rst_done",  32'(DONE),    32'h0);
      chk("rst_winc",  32'(W_INC),   32'h0);
      chk("rst_wdata", 32'(WR_DATA), 32'h0);
      chk("rst_busy",  32'(BUSY),    32'h0);
      step();
      RST = 1'b1;
      step();

      // Single two-byte packet from requester 0
      REQ = 2'b01; REQ_DATA = 32'h0000_A55A; REQ_TWO = 2'b01;
      push_pkt(0, 16'hA55A, 1'b1);
      @(negedge CLK);
      chk("t1_gnt_c0",  32'(GNT),   32'h1);
      chk("t1_winc_c0", 32'(W_INC), 32'h0);
      step();
      REQ = 2'b00;
      @(negedge CLK);
      chk("t1_winc_c1", 32'(W_INC),   32'h1);
      chk("t1_data_c1", 32'(WR_DATA), 32'h5A);
      chk("t1_done_c1", 32'(DONE),    32'h0);
      step();
      @(negedge CLK);
      chk("t1_data_c2", 32'(WR_DATA), 32'hA5);
      chk("t1_done_c2", 32'(DONE),    32'h1);
      step();
      @(negedge CLK);
      chk("t1_busy_c3", 32'(BUSY),  32'h0);
      chk("t1_winc_c3", 32'(W_INC), 32'h0);

      // One-byte packet from requester 1 (pointer at 1)
      step();
      REQ = 2'b10; REQ_DATA = 32'h00C3_0000; REQ_TWO = 2'b00;
      push_pkt(1, 16'h00C3, 1'b0);
      @(negedge CLK);
      chk("t2_gnt", 32'(GNT), 32'h2);
      step();
      REQ = 2'b00;
      @(negedge CLK);
      chk("t2_winc", 32'(W_INC),   32'h1);
      chk("t2_data", 32'(WR_DATA), 32'hC3);
      chk("t2_done", 32'(DONE),    32'h2);
      step();
      @(negedge CLK);
      chk("t2_winc_after", 32'(W_INC),   32'h0);
      chk("t2_data_idle",  32'(WR_DATA), 32'h0);
      chk("t2_busy_after", 32'(BUSY),    32'h0);

      // Contention: both requesters always requesting, order 0,1,0,1
      q0.push_back('{16'h1122, 1'b1});
      q0.push_back('{16'h0033, 1'b0});
      q1.push_back('{16'h4455, 1'b1});
      q1.push_back('{16'h0066, 1'b0});
      push_pairs();
      run_streams(1'b0);

      // FULL held for 4 cycles during the upper byte
      step();
      REQ = 2'b01; REQ_DATA = 32'h0000_BEEF; REQ_TWO = 2'b01;
      push_pkt(0, 16'hBEEF, 1'b1);
      @(negedge CLK);
      chk("t4_gnt", 32'(GNT), 32'h1);
      step();
      REQ = 2'b00;
      @(negedge CLK);
      chk("t4_lo_data", 32'(WR_DATA), 32'hEF);
      step();
      FULL = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         chk("t4_full_winc", 32'(W_INC),   32'h1);
         chk("t4_full_data", 32'(WR_DATA), 32'hBE);
         chk("t4_full_done", 32'(DONE),    32'h0);
         step();
      end
      FULL = 1'b0;
      @(negedge CLK);
      chk("t4_release_data", 32'(WR_DATA), 32'hBE);
      chk("t4_release_done", 32'(DONE),    32'h1);
      step();
      @(negedge CLK);
      chk("t4_winc_after", 32'(W_INC), 32'h0);

      // Reset mid-packet: requester 1 in SEND_LO, stalled by FULL
      step();
      REQ = 2'b10; REQ_DATA = 32'h7788_0000; REQ_TWO = 2'b10;
      exp_gnt.push_back(2'b10);
      iss_gnt[1]++;
      @(negedge CLK);
      chk("t5_gnt", 32'(GNT), 32'h2);
      step();
      REQ  = 2'b00;
      FULL = 1'b1;
      @(negedge CLK);
      chk("t5_lo_data", 32'(WR_DATA), 32'h88);
      #2 RST = 1'b0;
      #1;
      chk("t5_rst_gnt",   32'(GNT),     32'h0);
      chk("t5_rst_done",  32'(DONE),    32'h0);
      chk("t5_rst_winc",  32'(W_INC),   32'h0);
      chk("t5_rst_wdata", 32'(WR_DATA), 32'h0);
      chk("t5_rst_busy",  32'(BUSY),    32'h0);
      step();
      step();
      RST  = 1'b1;
      FULL = 1'b0;
      // Pointer back at 0: requester 0 wins first
      q0.push_back('{16'h00A1, 1'b0});
      q1.push_back('{16'h00B2, 1'b0});
      push_pairs();
      run_streams(1'b0);

      // 200 random packets with random FULL
      for (int k = 0; k < 100; k++) begin
         q0.push_back('{16'($urandom), 1'($urandom_range(0, 1))});
         q1.push_back('{16'($urandom), 1'($urandom_range(0, 1))});
      end
      push_pairs();
      run_streams(1'b1);

      repeat (2) step();
      chk("left_gnt",  32'(exp_gnt.size()),  32'h0);
      chk("left_byte", 32'(exp_byte.size()), 32'h0);
      chk("left_done", 32'(exp_done.size()), 32'h0);
      for (int i = 0; i < 2; i++) begin
         chk("gnt_count",  32'(gnt_cnt[i]),  32'(iss_gnt[i]));
         chk("done_count", 32'(done_cnt[i]), 32'(iss_done[i]));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
